pc_unit: RTL

//  Parametrised fetch-address generator for the pipelined CPU (F stage).

---
 rtl/pc_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-address generator with stall, deferred redirect, exception
//            vector, ERET return, fetch-fault flag and advance counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IM_BASE   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IM_BYTES  = 32'h0000_4000,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_req_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc4_o,
  output logic             pend_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  // One extra bit so the end of the window never wraps to zero.
  localparam logic [WIDTH:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;
  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    adv     = 1'b0;
    if (exc_req_i) begin
      pc_d    = EXC_VEC;
      state_d = RUN;
      tgt_d   = '0;
      adv     = 1'b1;
    end else if (eret_i) begin
      pc_d    = epc_i;
      state_d = RUN;
      tgt_d   = '0;
      adv     = 1'b1;
    end else if (stall_i) begin
      // A newer branch under stall replaces any older pending target.
      if (br_valid_i) begin
        tgt_d   = br_target_i;
        state_d = PEND;
      end
    end else if (br_valid_i) begin
      pc_d    = br_target_i;
      state_d = RUN;
      adv     = 1'b1;
    end else if (state_q == PEND) begin
      pc_d    = tgt_q;
      state_d = RUN;
      adv     = 1'b1;
    end else begin
      pc_d = pc_plus4;
      adv  = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(adv);
  end

  assign pc_o        = pc_q;
  assign pc4_o       = pc_plus4;
  assign pend_o      = (state_q == PEND);
  assign fetch_cnt_o = cnt_q;
  assign fault_o     = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) ||
                       ({1'b0, pc_q} >= IM_END);

endmodule

`default_nettype wire
